// File: rtl/if_fetch_queue.sv
// if_fetch_queue
// Instruction-fetch front end: owns the fetch PC, addresses the combinational
// instruction ROM and buffers fetched {pc, inst} pairs in a small FIFO so that
// decode stalls do not stall fetch until the queue fills. Two redirect sources
// (exception/MRET and branch/jump) flush the queue and reload the fetch PC.
module if_fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter int          IMEM_AW  = 7,
  parameter logic [31:0] RESET_PC = 32'h0,
  parameter logic [31:0] NOP_INST = 32'h00000013
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic [IMEM_AW-1:0]         imem_addr,
  input  logic [31:0]                imem_data,
  input  logic                       redirect_exp,
  input  logic [31:0]                redirect_exp_pc,
  input  logic                       redirect_br,
  input  logic [31:0]                redirect_br_pc,
  input  logic                       deq_ready,
  output logic                       deq_valid,
  output logic [31:0]                deq_pc,
  output logic [31:0]                deq_inst,
  output logic [$clog2(DEPTH):0]     count,
  output logic [31:0]                fetch_pc
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [31:0]   pc_mem   [DEPTH];
  logic [31:0]   inst_mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;

  logic          redir;
  logic          not_empty;
  logic          deq_fire;
  logic          enq_fire;
  logic [31:0]   redir_target;

  assign imem_addr = fetch_pc[IMEM_AW+1:2];

  // Firing conditions; the exception redirect outranks the branch redirect.
  always_comb begin
    redir        = redirect_exp | redirect_br;
    redir_target = redirect_exp ? redirect_exp_pc : redirect_br_pc;
    not_empty    = (count != '0);
    deq_valid    = not_empty & ~redir;
    deq_fire     = deq_valid & deq_ready;
    enq_fire     = ~redir & ((count < CW'(DEPTH)) | deq_fire);
    deq_pc       = not_empty ? pc_mem[rd_ptr]   : 32'h0;
    deq_inst     = not_empty ? inst_mem[rd_ptr] : NOP_INST;
  end

  // Queue storage carries no reset; validity comes only from count.
  always_ff @(posedge clk) begin
    if (enq_fire) begin
      pc_mem[wr_ptr]   <= fetch_pc;
      inst_mem[wr_ptr] <= imem_data;
    end
  end

  // Fetch PC, pointers and occupancy; a redirect flushes and reloads the PC.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc <= RESET_PC;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else if (redir) begin
      fetch_pc <= {redir_target[31:2], 2'b00};
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else begin
      if (enq_fire) begin
        fetch_pc <= fetch_pc + 32'd4;
        wr_ptr   <= wr_ptr + PW'(1);
      end
      if (deq_fire) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({enq_fire, deq_fire})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch_queue.sv
// tb_if_fetch_queue
// Directed bench for if_fetch_queue with a scoreboard queue of expected
// {pc, inst} entries and a reference fetch PC.
module tb_if_fetch_queue;

  localparam int          DEPTH    = 4;
  localparam int          IMEM_AW  = 7;
  localparam logic [31:0] RESET_PC = 32'h0;
  localparam logic [31:0] NOP_INST = 32'h00000013;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } entry_t;

  logic                 clk;
  logic                 rst;
  logic [IMEM_AW-1:0]   imem_addr;
  logic [31:0]          imem_data;
  logic                 redirect_exp;
  logic [31:0]          redirect_exp_pc;
  logic                 redirect_br;
  logic [31:0]          redirect_br_pc;
  logic                 deq_ready;
  logic                 deq_valid;
  logic [31:0]          deq_pc;
  logic [31:0]          deq_inst;
  logic [2:0]           count;
  logic [31:0]          fetch_pc;

  int     n_cmp;
  int     n_fail;
  entry_t sb[$];
  logic [31:0] model_pc;

  if_fetch_queue #(
    .DEPTH(DEPTH), .IMEM_AW(IMEM_AW), .RESET_PC(RESET_PC), .NOP_INST(NOP_INST)
  ) dut (
    .clk(clk), .rst(rst),
    .imem_addr(imem_addr), .imem_data(imem_data),
    .redirect_exp(redirect_exp), .redirect_exp_pc(redirect_exp_pc),
    .redirect_br(redirect_br), .redirect_br_pc(redirect_br_pc),
    .deq_ready(deq_ready), .deq_valid(deq_valid),
    .deq_pc(deq_pc), .deq_inst(deq_inst),
    .count(count), .fetch_pc(fetch_pc)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Combinational ROM contents, distinct per word address.
  function automatic logic [31:0] rom_val(input logic [IMEM_AW-1:0] a);
    return 32'hA500_0000 ^ ({25'd0, a} * 32'h0001_0103);
  endfunction

  assign imem_data = rom_val(imem_addr);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Compare all observable outputs against the scoreboard and reference PC.
  task automatic check_outputs(input string tag);
    logic redir;
    logic exp_valid;
    redir     = redirect_exp | redirect_br;
    exp_valid = (sb.size() != 0) && !redir;
    check({tag, ".count"},     32'(count),     32'(sb.size()));
    check({tag, ".fetch_pc"},  fetch_pc,       model_pc);
    check({tag, ".imem_addr"}, 32'(imem_addr), 32'(model_pc[IMEM_AW+1:2]));
    check({tag, ".valid"},     32'(deq_valid), 32'(exp_valid));
    if (sb.size() == 0) begin
      check({tag, ".empty_pc"},   deq_pc,   32'h0);
      check({tag, ".empty_inst"}, deq_inst, NOP_INST);
    end else if (exp_valid) begin
      check({tag, ".deq_pc"},   deq_pc,   sb[0].pc);
      check({tag, ".deq_inst"}, deq_inst, sb[0].inst);
    end
  endtask

  // Drive one cycle of stimulus, check, advance the model across the next edge.
  task automatic step(input string tag, input logic rdy,
                      input logic br, input logic [31:0] br_pc,
                      input logic ex, input logic [31:0] ex_pc);
    logic   deq;
    logic   enq;
    entry_t e;
    deq_ready       = rdy;
    redirect_br     = br;
    redirect_br_pc  = br_pc;
    redirect_exp    = ex;
    redirect_exp_pc = ex_pc;
    #1;
    check_outputs(tag);
    if (br || ex) begin
      sb.delete();
      model_pc = ex ? {ex_pc[31:2], 2'b00} : {br_pc[31:2], 2'b00};
    end else begin
      deq = (sb.size() != 0) && rdy;
      enq = (sb.size() < DEPTH) || deq;
      if (deq) void'(sb.pop_front());
      if (enq) begin
        e.pc   = model_pc;
        e.inst = rom_val(model_pc[IMEM_AW+1:2]);
        sb.push_back(e);
        model_pc = model_pc + 32'd4;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    n_cmp    = 0;
    n_fail   = 0;
    model_pc = RESET_PC;
    rst             = 1'b0;
    deq_ready       = 1'b1;
    redirect_br     = 1'b0;
    redirect_br_pc  = 32'h0;
    redirect_exp    = 1'b0;
    redirect_exp_pc = 32'h0;
    #1;
    check_outputs("reset");

    // Release reset; first edge enqueues PC 0, visible one cycle later.
    @(negedge clk);
    rst = 1'b1;
    step("rel", 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);

    // ID stalled: fill to DEPTH, then hold with fetch_pc and imem_addr frozen.
    for (int i = 0; i < 7; i++) step("stall", 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    check("full.count",    32'(count), 32'(DEPTH));
    check("full.fetch_pc", fetch_pc,   32'h10);

    // Streaming while full: one entry per cycle, occupancy stays at DEPTH.
    for (int i = 0; i < 6; i++) step("stream", 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);

    // Branch redirect from a full queue; low PC bits are cleared.
    step("br",     1'b1, 1'b1, 32'h42, 1'b0, 32'h0);
    step("br+1",   1'b1, 1'b0, 32'h0,  1'b0, 32'h0);
    step("br+2",   1'b1, 1'b0, 32'h0,  1'b0, 32'h0);
    check("br.head_pc", deq_pc, 32'h44);

    // Both redirects together: the exception target wins.
    step("both",   1'b0, 1'b1, 32'h40, 1'b1, 32'h100);
    step("both+1", 1'b0, 1'b0, 32'h0,  1'b0, 32'h0);
    check("both.fetch_pc", fetch_pc, 32'h104);

    // Back-to-back redirects: the last target wins.
    step("rr1",    1'b1, 1'b1, 32'h200, 1'b0, 32'h0);
    step("rr2",    1'b1, 1'b1, 32'h300, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) step("rr+", 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);

    // Fetch PC wraps from 0xFFFFFFFC to 0.
    step("wrap",   1'b0, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFF8);
    for (int i = 0; i < 5; i++) step("wrap+", 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    for (int i = 0; i < 5; i++) step("drain", 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);

    // Asynchronous reset mid-stream, between clock edges.
    #2;
    rst = 1'b0;
    #1;
    sb.delete();
    model_pc = RESET_PC;
    check("arst.count",    32'(count),     32'h0);
    check("arst.valid",    32'(deq_valid), 32'h0);
    check("arst.fetch_pc", fetch_pc,       RESET_PC);
    check_outputs("arst");
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) step("post", 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
